gate_sweep_checker: RTL and testbench



---
 rtl/gate_pkg.sv | 29 ++
 rtl/gate_golden.sv | 33 +++
 rtl/gate_sweep_checker.sv | 127 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared encodings for the gate sweep checker: golden-function
//               mode codes, sweep FSM states and a reserved-mode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

  // Golden-function selection codes (6 and 7 are reserved)
  localparam logic [2:0] MODE_NOR  = 3'd0;
  localparam logic [2:0] MODE_NAND = 3'd1;
  localparam logic [2:0] MODE_AND  = 3'd2;
  localparam logic [2:0] MODE_OR   = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  // Sweep FSM state encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  // A reserved mode skips the sweep entirely and reports a failed result
  function automatic logic is_reserved(input logic [2:0] m);
    return (m > MODE_XNOR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_golden.sv
`default_nettype none
// ============================================================================
// Module      : gate_golden
// Description : Combinational reference model of an N-input reduction gate.
//               Reserved modes return 0.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_golden
  import gate_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2:0]   mode,
  input  logic [N-1:0] vec,
  output logic         y
);

  // Select the reduction operator that defines the expected gate output
  always_comb begin
    y = 1'b0;
    case (mode)
      MODE_NOR:  y = ~(|vec);
      MODE_NAND: y = ~(&vec);
      MODE_AND:  y = &vec;
      MODE_OR:   y = |vec;
      MODE_XOR:  y = ^vec;
      MODE_XNOR: y = ~(^vec);
      default:   y = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker
// Description : Drives all 2^N input vectors in ascending order onto a gate
//               under test, holds each for HOLD cycles, compares the gate
//               output with a golden function on the last hold cycle and
//               reports pass, a saturating mismatch count and the first
//               failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N     = 3,
  parameter int HOLD  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [N-1:0]     stim,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N-1:0]     first_fail,
  output logic             first_fail_valid
);

  // Hold counter needs at least one bit even when HOLD is 1
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]    c_hold_last = HW'(HOLD - 1);
  localparam logic [N-1:0]     c_stim_last = '1;
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  logic [1:0]       r_state;
  logic [2:0]       r_mode;
  logic [HW-1:0]    r_hold;
  logic [N-1:0]     r_stim;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err;
  logic [N-1:0]     r_ff;
  logic             r_ffv;
  logic             w_golden;

  gate_golden #(.N(N)) u_golden (
    .mode (r_mode),
    .vec  (r_stim),
    .y    (w_golden)
  );

  // Sweep FSM: accept start, walk vectors with per-vector hold, score results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= MODE_NOR;
      r_hold  <= '0;
      r_stim  <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_ff    <= '0;
      r_ffv   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_err   <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
            r_pass  <= 1'b0;
            r_stim  <= '0;
            r_hold  <= '0;
            r_state <= is_reserved(mode) ? FINISH : DRIVE;
          end
        end
        DRIVE: begin
          if (r_hold == c_hold_last) begin
            // Sample the gate only on the last hold cycle to absorb its latency
            if (w_golden != dut_y) begin
              if (r_err != c_cnt_max) begin
                r_err <= r_err + 1'b1;
              end
              if (!r_ffv) begin
                r_ff  <= r_stim;
                r_ffv <= 1'b1;
              end
            end
            r_hold <= '0;
            if (r_stim == c_stim_last) begin
              r_state <= FINISH;
            end else begin
              r_stim <= r_stim + 1'b1;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        FINISH: begin
          // Final compare has already landed, so the mismatch flag is complete
          r_done  <= 1'b1;
          r_pass  <= !is_reserved(r_mode) && !r_ffv;
          r_stim  <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stim             = r_stim;
  assign busy             = (r_state == DRIVE);
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err;
  assign first_fail       = r_ff;
  assign first_fail_valid = r_ffv;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_checker
// Description : Scoreboard bench for gate_sweep_checker. Sweeps are issued
//               with hand-computed expected results pushed into a queue; a
//               monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

  typedef struct {
    int          done_cyc;
    logic        pass;
    logic [15:0] err;
    logic [2:0]  ff;
    logic        ffv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  mode;
  logic [2:0]  stim;
  logic        dut_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [2:0]  first_fail;
  logic        first_fail_valid;

  logic        start_s;
  logic [2:0]  mode_s;
  logic [2:0]  stim_s;
  logic        busy_s;
  logic        done_s;
  logic        pass_s;
  logic [1:0]  err_count_s;
  logic [2:0]  first_fail_s;
  logic        first_fail_valid_s;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   kind;
  logic r_nor;
  exp_t q[$];
  exp_t q2[$];
  exp_t e_mon;
  exp_t e_mon2;

  gate_sweep_checker #(.N(3), .HOLD(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stim(stim),
    .dut_y(dut_y), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail),
    .first_fail_valid(first_fail_valid)
  );

  // Narrow-counter instance used for the saturation case; its gate is stuck at 0
  gate_sweep_checker #(.N(3), .HOLD(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .mode(mode_s), .stim(stim_s),
    .dut_y(1'b0), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_count_s), .first_fail(first_fail_s),
    .first_fail_valid(first_fail_valid_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test: nor_three with one cycle of latency, or stuck-at-0
  always @(posedge clk) r_nor <= ~(|stim);
  assign dut_y = (kind == 0) ? r_nor : 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Main scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e_mon = q.pop_front();
        chk("done_cycle", cyc, e_mon.done_cyc);
        chk("pass", {31'd0, pass}, {31'd0, e_mon.pass});
        chk("err_count", {16'd0, err_count}, {16'd0, e_mon.err});
        chk("first_fail", {29'd0, first_fail}, {29'd0, e_mon.ff});
        chk("first_fail_valid", {31'd0, first_fail_valid}, {31'd0, e_mon.ffv});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Saturation-instance scoreboard monitor
  always @(negedge clk) begin
    if (done_s) begin
      if (q2.size() == 0) begin
        chk("sat_unexpected_done", 32'd1, 32'd0);
      end else begin
        e_mon2 = q2.pop_front();
        chk("sat_done_cycle", cyc, e_mon2.done_cyc);
        chk("sat_pass", {31'd0, pass_s}, {31'd0, e_mon2.pass});
        chk("sat_err_count", {30'd0, err_count_s}, {16'd0, e_mon2.err});
        chk("sat_first_fail", {29'd0, first_fail_s}, {29'd0, e_mon2.ff});
        chk("sat_first_fail_valid", {31'd0, first_fail_valid_s}, {31'd0, e_mon2.ffv});
      end
    end
  end

  // Pulse start for one edge; k is the cycle count of the accepting edge
  task automatic issue(input logic [2:0] m, input int dk, input bit push,
                       input logic ep, input int ee, input int eff, input logic effv,
                       output int k);
    exp_t e;
    @(negedge clk);
    mode  = m;
    kind  = dk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    if (push) begin
      e.done_cyc = (m > 3'd5) ? k + 1 : k + 33;
      e.pass = ep;
      e.err  = 16'(ee);
      e.ff   = 3'(eff);
      e.ffv  = effv;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size() + q2.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int k;
    exp_t e;
    rst = 1'b1; start = 1'b0; mode = 3'd0; kind = 0;
    start_s = 1'b0; mode_s = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_stim", {29'd0, stim}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outputs", {done, pass, first_fail_valid, first_fail, err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Correct nor_three, mode NOR: stim walks 0..7, clean pass
    issue(3'd0, 0, 1'b1, 1'b1, 0, 0, 1'b0, k);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int v = 0; v < 8; v++) begin
      wait_cyc(k + 4 * v + 1);
      chk("stim_walk", {29'd0, stim}, v);
    end
    drain();

    // NAND golden against nor_three: vectors 1..6 mismatch
    issue(3'd1, 0, 1'b1, 1'b0, 6, 1, 1'b1, k);
    drain();

    // Stuck-at-0 gate in NOR mode: only vector 0 mismatches
    issue(3'd0, 1, 1'b1, 1'b0, 1, 0, 1'b1, k);
    drain();

    // XOR on the 2-bit counter instance: four mismatches saturate at 3
    @(negedge clk);
    mode_s = 3'd4;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    e.done_cyc = cyc + 33; e.pass = 1'b0; e.err = 16'd3; e.ff = 3'd1; e.ffv = 1'b1;
    q2.push_back(e);
    drain();

    // Reserved mode: immediate done, nothing driven
    issue(3'd6, 0, 1'b1, 1'b0, 0, 0, 1'b0, k);
    chk("reserved_stim", {29'd0, stim}, 32'd0);
    chk("reserved_busy", {31'd0, busy}, 32'd0);
    drain();

    // Start and mode change mid-sweep are ignored; result and timing unchanged
    issue(3'd0, 0, 1'b1, 1'b1, 0, 0, 1'b0, k);
    wait_cyc(k + 10);
    start = 1'b1;
    mode = 3'd1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid_sweep", {31'd0, busy}, 32'd1);
    drain();

    // Asynchronous reset at vector 3 mid-hold: sweep abandoned, no done
    issue(3'd0, 0, 1'b0, 1'b0, 0, 0, 1'b0, k);
    wait_cyc(k + 14);
    chk("pre_reset_stim", {29'd0, stim}, 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stim", {29'd0, stim}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_outputs", {done, pass, first_fail_valid, first_fail, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Clean sweep after the reset
    issue(3'd0, 0, 1'b1, 1'b1, 0, 0, 1'b0, k);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
